// File: rtl/control_pkg.sv
// Shared encodings for the RV32I single-cycle control unit: opcodes, ALU codes,
// immediate/writeback selects and ALU flag bit positions.
package control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int ALU_W = 4;

    // Codes 0xB-0xF are reserved and never produced by the decoder.
    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SLL  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_ADDI = 4'h5,
        ALU_OR   = 4'h6,
        ALU_AND  = 4'h7,
        ALU_SUB  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA
    } alu_op_e;

    // Coarse operation class handed from the main decoder to the ALU decoder.
    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_SUB = 2'd1,
        CLS_R   = 2'd2,
        CLS_I   = 2'd3
    } alu_class_e;

    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_SB = 2'b01;
    localparam logic [1:0] IMM_U  = 2'b10;
    localparam logic [1:0] IMM_J  = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU decoder: turns the main decoder's operation class plus funct3/funct7[5]
// into the 4-bit ALU operation code.
module alu_decoder
    import control_pkg::*;
(
    input  alu_class_e       alu_class_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7_i,
    output logic [ALU_W-1:0] alu_control_o
);

    alu_op_e alu_op;

    always_comb begin
        alu_op = ALU_ADD;
        case (alu_class_i)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_R, CLS_I: begin
                case (funct3_i)
                    3'b000: begin
                        // funct7[5] selects SUB only for register-register ops
                        if (alu_class_i == CLS_I) alu_op = ALU_ADDI;
                        else                      alu_op = funct7_i ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alu_control_o = alu_op;

endmodule

// File: rtl/control_unit.sv
// Main decoder and branch resolver for a single-cycle RV32I core, plus a sticky
// flag recording that an unsupported opcode was decoded since reset.
module control_unit
    import control_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7,
    input  logic [3:0]       flags,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             MemWrite,
    output logic             PCSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       ResultSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic             illegal,
    output logic             illegal_sticky
);

    alu_class_e alu_class;
    logic       is_branch;
    logic       is_jump;
    logic       branch_taken;
    logic       illegal_sticky_q;
    logic       illegal_sticky_d;

    always_comb begin
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        MemWrite  = 1'b0;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALU;
        alu_class = CLS_ADD;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_R: begin
                RegWrite  = 1'b1;
                alu_class = CLS_R;
            end
            OP_I: begin
                RegWrite  = 1'b1;
                ALUSrc    = 1'b1;
                alu_class = CLS_I;
            end
            OP_LOAD: begin
                RegWrite  = 1'b1;
                ALUSrc    = 1'b1;
                ResultSrc = RES_MEM;
            end
            OP_STORE: begin
                ALUSrc    = 1'b1;
                MemWrite  = 1'b1;
                ImmSrc    = IMM_SB;
            end
            OP_BRANCH: begin
                ImmSrc    = IMM_SB;
                alu_class = CLS_SUB;
                is_branch = 1'b1;
            end
            OP_JAL: begin
                RegWrite  = 1'b1;
                ImmSrc    = IMM_J;
                ResultSrc = RES_PC4;
                is_jump   = 1'b1;
            end
            OP_LUI: begin
                RegWrite  = 1'b1;
                ImmSrc    = IMM_U;
            end
            // JALR and AUIPC fall here too: everything stays at zero
            default: illegal = 1'b1;
        endcase
    end

    // Flags come from the SUB the ALU performs for the branch compare.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = flags[FLAG_Z];
            3'b001: branch_taken = !flags[FLAG_Z];
            3'b100: branch_taken = flags[FLAG_N] ^ flags[FLAG_V];
            3'b101: branch_taken = !(flags[FLAG_N] ^ flags[FLAG_V]);
            3'b110: branch_taken = !flags[FLAG_C];
            3'b111: branch_taken = flags[FLAG_C];
            default: branch_taken = 1'b0;
        endcase
    end

    assign PCSrc = is_jump | (is_branch & branch_taken);

    alu_decoder u_alu_decoder (
        .alu_class_i   (alu_class),
        .funct3_i      (funct3),
        .funct7_i      (funct7),
        .alu_control_o (ALUControl)
    );

    assign illegal_sticky_d = illegal_sticky_q | illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_sticky_q <= 1'b0;
        else     illegal_sticky_q <= illegal_sticky_d;
    end

    assign illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed checks of the RV32I control unit: per-class decode, branch resolution,
// the sticky illegal flag, and a full op/funct3/funct7/flags sweep.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic [3:0] flags;
    logic       RegWrite, ALUSrc, MemWrite, PCSrc, illegal, illegal_sticky;
    logic [1:0] ImmSrc, ResultSrc;
    logic [3:0] ALUControl;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk            (clk),
        .rst            (rst),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .flags          (flags),
        .RegWrite       (RegWrite),
        .ALUSrc         (ALUSrc),
        .MemWrite       (MemWrite),
        .PCSrc          (PCSrc),
        .ImmSrc         (ImmSrc),
        .ResultSrc      (ResultSrc),
        .ALUControl     (ALUControl),
        .illegal        (illegal),
        .illegal_sticky (illegal_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed decode bundle: {RegWrite,ALUSrc,MemWrite,PCSrc,ImmSrc,ResultSrc,ALUControl,illegal}
    function automatic logic [12:0] bundle();
        return {RegWrite, ALUSrc, MemWrite, PCSrc, ImmSrc, ResultSrc, ALUControl, illegal};
    endfunction

    function automatic logic [12:0] exp_b(input logic rw, input logic as, input logic mw,
                                          input logic pc, input logic [1:0] imm,
                                          input logic [1:0] res, input logic [3:0] alu,
                                          input logic ill);
        return {rw, as, mw, pc, imm, res, alu, ill};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [3:0] fl);
        op     = o;
        funct3 = f3;
        funct7 = f7;
        flags  = fl;
        #1;
    endtask

    // Independent reference for the sweep: which (op, f3, flags) must redirect the PC.
    function automatic logic exp_pcsrc(input logic [6:0] o, input logic [2:0] f3,
                                       input logic [3:0] fl);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        if (o == 7'b1101111) return 1'b1;
        if (o != 7'b1100011) return 1'b0;
        case (f3)
            3'd0: return z;
            3'd1: return ~z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return ~c;
            3'd7: return c;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic [6:0] o;
        logic       leg;
        rst = 1'b1;
        drive(7'b0110011, 3'd0, 1'b0, 4'h0);
        check("reset_sticky", {12'd0, illegal_sticky}, 13'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type
        drive(7'b0110011, 3'd0, 1'b0, 4'hF);
        check("r_add", bundle(), exp_b(1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0));
        drive(7'b0110011, 3'd0, 1'b1, 4'h0);
        check("r_sub", bundle(), exp_b(1, 0, 0, 0, 2'b00, 2'b00, 4'h8, 0));
        drive(7'b0110011, 3'd5, 1'b1, 4'h0);
        check("r_sra", bundle(), exp_b(1, 0, 0, 0, 2'b00, 2'b00, 4'hA, 0));
        drive(7'b0110011, 3'd5, 1'b0, 4'h0);
        check("r_srl", bundle(), exp_b(1, 0, 0, 0, 2'b00, 2'b00, 4'h9, 0));
        drive(7'b0110011, 3'd3, 1'b1, 4'h0);
        check("r_sltu", bundle(), exp_b(1, 0, 0, 0, 2'b00, 2'b00, 4'h3, 0));
        drive(7'b0110011, 3'd7, 1'b0, 4'h0);
        check("r_and", bundle(), exp_b(1, 0, 0, 0, 2'b00, 2'b00, 4'h7, 0));

        // I-type arithmetic: funct7 only matters for shifts-right
        drive(7'b0010011, 3'd0, 1'b0, 4'h0);
        check("addi", bundle(), exp_b(1, 1, 0, 0, 2'b00, 2'b00, 4'h5, 0));
        drive(7'b0010011, 3'd0, 1'b1, 4'h0);
        check("addi_f7", bundle(), exp_b(1, 1, 0, 0, 2'b00, 2'b00, 4'h5, 0));
        drive(7'b0010011, 3'd5, 1'b1, 4'h0);
        check("srai", bundle(), exp_b(1, 1, 0, 0, 2'b00, 2'b00, 4'hA, 0));
        drive(7'b0010011, 3'd6, 1'b1, 4'h0);
        check("ori", bundle(), exp_b(1, 1, 0, 0, 2'b00, 2'b00, 4'h6, 0));
        drive(7'b0010011, 3'd4, 1'b0, 4'h0);
        check("xori", bundle(), exp_b(1, 1, 0, 0, 2'b00, 2'b00, 4'h4, 0));

        // Load / store
        drive(7'b0000011, 3'd2, 1'b1, 4'hF);
        check("load", bundle(), exp_b(1, 1, 0, 0, 2'b00, 2'b01, 4'h0, 0));
        drive(7'b0100011, 3'd2, 1'b1, 4'hF);
        check("store", bundle(), exp_b(0, 1, 1, 0, 2'b01, 2'b00, 4'h0, 0));

        // JAL / LUI
        drive(7'b1101111, 3'd0, 1'b0, 4'h0);
        check("jal", bundle(), exp_b(1, 0, 0, 1, 2'b11, 2'b10, 4'h0, 0));
        drive(7'b0110111, 3'd5, 1'b1, 4'hF);
        check("lui", bundle(), exp_b(1, 0, 0, 0, 2'b10, 2'b00, 4'h0, 0));

        // Branches, flags = {N,Z,C,V}
        drive(7'b1100011, 3'd0, 1'b0, 4'b0100);
        check("beq_z1", bundle(), exp_b(0, 0, 0, 1, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd0, 1'b0, 4'b0000);
        check("beq_z0", bundle(), exp_b(0, 0, 0, 0, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd1, 1'b0, 4'b0100);
        check("bne_z1", bundle(), exp_b(0, 0, 0, 0, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd4, 1'b0, 4'b1000);
        check("blt_n1v0", bundle(), exp_b(0, 0, 0, 1, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd4, 1'b0, 4'b1001);
        check("blt_n1v1", bundle(), exp_b(0, 0, 0, 0, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd5, 1'b0, 4'b1000);
        check("bge_n1v0", bundle(), exp_b(0, 0, 0, 0, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd6, 1'b0, 4'b0000);
        check("bltu_c0", bundle(), exp_b(0, 0, 0, 1, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd7, 1'b0, 4'b0000);
        check("bgeu_c0", bundle(), exp_b(0, 0, 0, 0, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd7, 1'b0, 4'b0010);
        check("bgeu_c1", bundle(), exp_b(0, 0, 0, 1, 2'b01, 2'b00, 4'h8, 0));
        drive(7'b1100011, 3'd2, 1'b0, 4'b1111);
        check("br_f3_010", bundle(), exp_b(0, 0, 0, 0, 2'b01, 2'b00, 4'h8, 0));

        // Illegal opcode and sticky flag
        @(negedge clk);
        drive(7'b1111111, 3'd0, 1'b1, 4'hF);
        check("illegal_comb", bundle(), exp_b(0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 1));
        check("sticky_pre_edge", {12'd0, illegal_sticky}, 13'd0);
        @(posedge clk);
        #1;
        check("sticky_set", {12'd0, illegal_sticky}, 13'd1);
        drive(7'b0110011, 3'd0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("sticky_hold", {12'd0, illegal_sticky}, 13'd1);
        drive(7'b1100111, 3'd0, 1'b0, 4'h0);
        check("jalr_illegal", bundle(), exp_b(0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 1));
        drive(7'b0010111, 3'd0, 1'b0, 4'h0);
        check("auipc_illegal", bundle(), exp_b(0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("sticky_async_clr", {12'd0, illegal_sticky}, 13'd0);
        drive(7'b1101111, 3'd0, 1'b0, 4'h0);
        check("decode_in_reset", bundle(), exp_b(1, 0, 0, 1, 2'b11, 2'b10, 4'h0, 0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("sticky_stays_clr", {12'd0, illegal_sticky}, 13'd0);

        // Sweep every op/funct3/funct7/flags combination
        for (int i = 0; i < 128; i++) begin
            o = 7'(i);
            leg = (o == 7'b0110011) || (o == 7'b0010011) || (o == 7'b0000011) ||
                  (o == 7'b0100011) || (o == 7'b1100011) || (o == 7'b1101111) ||
                  (o == 7'b0110111);
            for (int f = 0; f < 256; f++) begin
                drive(o, 3'(f >> 5), f[4], 4'(f));
                check("sweep_no_x", {12'd0, $isunknown(bundle())}, 13'd0);
                check("sweep_pcsrc_ill", {11'd0, PCSrc, illegal},
                      {11'd0, exp_pcsrc(o, 3'(f >> 5), 4'(f)), ~leg});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
